adder3_operand_loader: RTL and testbench

// - Upstream/downstream sequencing stage for the 3-bit ripple adder: loads operand A,

---
 rtl/adder3_operand_loader.sv | 106 ++++++++++
 tb/tb_adder3_operand_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/adder3_operand_loader.sv
// adder3_operand_loader: button-sequenced operand loader and result capture around a 3-bit adder
//   Optional feature macro: SIGNED_OVF_EN (signed overflow flag; ovf tied to 0 when undefined)
//   clk, rst       : clock, synchronous active-high reset
//   btn_load       : raw bouncy push button
//   sw, cin_sw     : operand switches and carry-in switch
//   S, C_out       : combinational adder outputs
//   A, B, C_in     : registered adder operands
//   result, result_valid, ovf : captured {C_out,S}, its valid flag, signed overflow
//   state_o        : FSM state for LEDs
module adder3_operand_loader #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_load,
   input  logic [2:0] sw,
   input  logic       cin_sw,
   input  logic [2:0] S,
   input  logic       C_out,
   output logic [2:0] A,
   output logic [2:0] B,
   output logic       C_in,
   output logic [3:0] result,
   output logic       result_valid,
   output logic       ovf,
   output logic [1:0] state_o
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, ADD = 2'd2, SHOW = 2'd3} state_t;
   state_t           state_q;
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             deb_q, deb_prev_q, press_q;
   logic [2:0]       a_q, b_q;
   logic             c_q, valid_q, ovf_q, ovf_calc;
   logic [3:0]       result_q;
`ifdef SIGNED_OVF_EN
   assign ovf_calc = (a_q[2] == b_q[2]) && (S[2] != a_q[2]);
`else
   assign ovf_calc = 1'b0;
`endif
   // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
   // press is registered one cycle after the rising flip.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], btn_load};
         deb_prev_q <= deb_q;
         press_q    <= deb_q & ~deb_prev_q;
         if (sync_q[1] == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            deb_q <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD_A;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            LOAD_A: if (press_q) begin
               a_q     <= sw;
               state_q <= LOAD_B;
            end
            LOAD_B: if (press_q) begin
               b_q     <= sw;
               c_q     <= cin_sw;
               state_q <= ADD;
            end
            ADD: begin
               result_q <= {C_out, S};
               valid_q  <= 1'b1;
               ovf_q    <= ovf_calc;
               state_q  <= SHOW;
            end
            default: if (press_q) begin
               valid_q <= 1'b0;
               ovf_q   <= 1'b0;
               state_q <= LOAD_A;
            end
         endcase
      end
   end
   assign A            = a_q;
   assign B            = b_q;
   assign C_in         = c_q;
   assign result       = result_q;
   assign result_valid = valid_q;
   assign ovf          = ovf_q;
   assign state_o      = state_q;
endmodule

// File: tb/tb_adder3_operand_loader.sv
// tb_adder3_operand_loader: randomized and directed self-checking bench for adder3_operand_loader
module tb_adder3_operand_loader;
   localparam int D = 4;
   logic       clk = 1'b0, rst = 1'b0, btn_load = 1'b0, cin_sw = 1'b0, C_out;
   logic [2:0] sw = '0, S, A, B;
   logic       C_in, result_valid, ovf;
   logic [3:0] result;
   logic [1:0] state_o;
   int n_chk = 0, n_pass = 0;
   int n_press = 0, ea = 0, eb = 0, ec = 0, er = 0, ev = 0, eo = 0, es = 0;

   adder3_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .btn_load(btn_load), .sw(sw), .cin_sw(cin_sw),
      .S(S), .C_out(C_out), .A(A), .B(B), .C_in(C_in), .result(result),
      .result_valid(result_valid), .ovf(ovf), .state_o(state_o)
   );

   assign {C_out, S} = {1'b0, A} + {1'b0, B} + {3'b000, C_in};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".A"}, int'(A), ea);
      chk({tag, ".B"}, int'(B), eb);
      chk({tag, ".C_in"}, int'(C_in), ec);
      chk({tag, ".result"}, int'(result), er);
      chk({tag, ".valid"}, int'(result_valid), ev);
      chk({tag, ".ovf"}, int'(ovf), eo);
      chk({tag, ".state"}, int'(state_o), es);
   endtask

   function automatic int signed3(input int v);
      return (v >= 4) ? v - 8 : v;
   endfunction

   // Every third press starts a new addition; the second press of each triple completes it.
   task automatic model_press(input int swv, input int cinv);
      int sum;
      case (n_press % 3)
         0: begin ea = swv; es = 1; end
         1: begin
            eb = swv; ec = cinv; er = ea + eb + ec; ev = 1; es = 3;
            sum = signed3(ea) + signed3(eb) + cinv;
`ifdef SIGNED_OVF_EN
            eo = (sum > 3 || sum < -4) ? 1 : 0;
`else
            eo = 0;
`endif
         end
         default: begin ev = 0; eo = 0; es = 0; end
      endcase
      n_press++;
   endtask

   task automatic model_reset();
      n_press = 0; ea = 0; eb = 0; ec = 0; er = 0; ev = 0; eo = 0; es = 0;
   endtask

   task automatic do_press(input int swv, input int cinv, input string tag);
      sw = 3'(swv); cin_sw = cinv[0];
      btn_load = 1'b1;
      repeat (D + 6) tick();
      btn_load = 1'b0;
      repeat (D + 6) tick();
      model_press(swv, cinv);
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #1;
      do_reset();
      check_all("reset");
      // Press first sampled at edge n: pulse during cycle n+6, state moves at edge n+7.
      sw = 3'd3;
      btn_load = 1'b1;
      repeat (7) tick();
      chk("timing.before", int'(state_o), 0);
      tick();
      chk("timing.after", int'(state_o), 1);
      chk("timing.A", int'(A), 3);
      chk("timing.valid_pre", int'(result_valid), 0);
      repeat (20) tick();
      chk("timing.held", int'(state_o), 1);
      btn_load = 1'b0;
      repeat (D + 6) tick();
      model_press(3, 0);
      check_all("loadA3");
      // B-loading press: pulse at n+6, ADD at n+7, capture at n+8.
      sw = 3'd2; cin_sw = 1'b1;
      btn_load = 1'b1;
      repeat (8) tick();
      chk("lat.add_state", int'(state_o), 2);
      chk("lat.valid_early", int'(result_valid), 0);
      tick();
      chk("lat.valid", int'(result_valid), 1);
      btn_load = 1'b0;
      repeat (D + 6) tick();
      model_press(2, 1);
      check_all("sum6");
      do_press(0, 0, "show_exit");
      do_press(7, 0, "loadA7");
      do_press(7, 1, "sum15");
      do_press(0, 0, "exit2");
      do_press(3, 0, "loadA3b");
      do_press(1, 0, "sum4");
      do_press(0, 0, "exit3");
      // Bounce: alternating samples never accumulate a full debounce window.
      sw = 3'd6;
      for (int i = 0; i < 10; i++) begin
         btn_load = ~btn_load;
         tick();
      end
      chk("bounce.state", int'(state_o), 0);
      btn_load = 1'b1;
      repeat (6) tick();
      repeat (D + 6) tick();
      sw = 3'd1;
      btn_load = 1'b0;
      repeat (D + 6) tick();
      model_press(6, 0);
      check_all("bounce");
      // Reset while in LOAD_B discards loaded operands.
      do_reset();
      do_press(5, 0, "loadA5");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_all("midreset");
      for (int r = 0; r < 8; r++) begin
         do_press(int'($urandom_range(0, 7)), 0, "rndA");
         do_press(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), "rndB");
         do_press(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), "rndX");
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
